// File: rtl/urng_taus_pair.sv
// Dual taus88 uniform source for the AWGN datapath.
// Two lockstep generators feed a 48-bit log operand and a 16-bit angle.
module urng_taus_pair #(
  parameter logic [31:0] SEED_A1 = 32'd2,
  parameter logic [31:0] SEED_A2 = 32'd8,
  parameter logic [31:0] SEED_A3 = 32'd16,
  parameter logic [31:0] SEED_B1 = 32'd2,
  parameter logic [31:0] SEED_B2 = 32'd8,
  parameter logic [31:0] SEED_B3 = 32'd16,
  parameter logic [15:0] WARMUP  = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reseed,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [47:0] u0,
  output logic [15:0] u1,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_WARM,
    S_RUN
  } state_e;

  // Low bits are forced so no component can lock up at zero.
  localparam logic [31:0] A1_INIT = SEED_A1 | 32'h2;
  localparam logic [31:0] A2_INIT = SEED_A2 | 32'h8;
  localparam logic [31:0] A3_INIT = SEED_A3 | 32'h10;
  localparam logic [31:0] B1_INIT = SEED_B1 | 32'h2;
  localparam logic [31:0] B2_INIT = SEED_B2 | 32'h8;
  localparam logic [31:0] B3_INIT = SEED_B3 | 32'h10;
  localparam logic [15:0] WARM_LAST = WARMUP - 16'd1;

  function automatic logic [31:0] t1(input logic [31:0] s);
    return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction

  function automatic logic [31:0] t2(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction

  function automatic logic [31:0] t3(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  state_e      state_q;
  logic [15:0] cnt_q;
  logic        valid_q;
  logic        busy_q;
  logic [47:0] u0_q;
  logic [15:0] u1_q;

  logic [31:0] a1_q, a2_q, a3_q;
  logic [31:0] b1_q, b2_q, b3_q;
  logic [31:0] a1_d, a2_d, a3_d;
  logic [31:0] b1_d, b2_d, b3_d;
  logic [31:0] wa, wb;
  logic [47:0] raw0;
  logic [47:0] u0_d;
  logic [15:0] u1_d;
  logic        take;

  assign a1_d = t1(a1_q);
  assign a2_d = t2(a2_q);
  assign a3_d = t3(a3_q);
  assign b1_d = t1(b1_q);
  assign b2_d = t2(b2_q);
  assign b3_d = t3(b3_q);

  assign wa   = a1_d ^ a2_d ^ a3_d;
  assign wb   = b1_d ^ b2_d ^ b3_d;
  assign raw0 = {wa, wb[31:16]};
  assign u0_d = (raw0 == 48'd0) ? 48'd1 : raw0;
  assign u1_d = wb[15:0];
  assign take = !valid_q || out_ready;

  assign out_valid = valid_q;
  assign u0        = u0_q;
  assign u1        = u1_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q    <= A1_INIT;
      a2_q    <= A2_INIT;
      a3_q    <= A3_INIT;
      b1_q    <= B1_INIT;
      b2_q    <= B2_INIT;
      b3_q    <= B3_INIT;
      state_q <= S_LOAD;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
      u0_q    <= '0;
      u1_q    <= '0;
    end else if (reseed) begin
      a1_q    <= A1_INIT;
      a2_q    <= A2_INIT;
      a3_q    <= A3_INIT;
      b1_q    <= B1_INIT;
      b2_q    <= B2_INIT;
      b3_q    <= B3_INIT;
      state_q <= S_LOAD;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          cnt_q <= '0;
          if (WARMUP != 16'd0) begin
            state_q <= S_WARM;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
          end
        end
        S_WARM: begin
          a1_q <= a1_d;
          a2_q <= a2_d;
          a3_q <= a3_d;
          b1_q <= b1_d;
          b2_q <= b2_d;
          b3_q <= b3_d;
          if (cnt_q == WARM_LAST) begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RUN: begin
          if (take) begin
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            a3_q    <= a3_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            b3_q    <= b3_d;
            u0_q    <= u0_d;
            u1_q    <= u1_d;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_LOAD;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urng_taus_pair.sv
// Scoreboard bench for urng_taus_pair: three instances
// (default, warm-up of 3, zero seeds) checked against hand-derived words.
module tb_urng_taus_pair;

  typedef struct {
    logic [47:0] u0;
    logic [15:0] u1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        rs_m, rm, v_m, b_m;
  logic [47:0] u0_m;
  logic [15:0] u1_m;
  logic        rs_z, rz, v_z, b_z;
  logic [47:0] u0_z;
  logic [15:0] u1_z;
  logic        rs_w, rw, v_w, b_w;
  logic [47:0] u0_w;
  logic [15:0] u1_w;

  int errors = 0;
  int checks = 0;

  exp_t q_m[$];
  exp_t q_z[$];
  exp_t q_w[$];

  urng_taus_pair dut_m (
    .clk(clk), .rst_n(rst_n), .reseed(rs_m), .out_ready(rm),
    .out_valid(v_m), .u0(u0_m), .u1(u1_m), .busy(b_m)
  );

  urng_taus_pair #(
    .SEED_A1(32'd0), .SEED_A2(32'd0), .SEED_A3(32'd0),
    .SEED_B1(32'd0), .SEED_B2(32'd0), .SEED_B3(32'd0)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .reseed(rs_z), .out_ready(rz),
    .out_valid(v_z), .u0(u0_z), .u1(u1_z), .busy(b_z)
  );

  urng_taus_pair #(
    .WARMUP(16'd3)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .reseed(rs_w), .out_ready(rw),
    .out_valid(v_w), .u0(u0_w), .u1(u1_w), .busy(b_w)
  );

  function automatic exp_t mk(input int i);
    exp_t t;
    case (i)
      1:       begin t.u0 = 48'h0020_2080_0020; t.u1 = 16'h2080; end
      2:       begin t.u0 = 48'h0200_2C80_0200; t.u1 = 16'h2C80; end
      3:       begin t.u0 = 48'h4808_8062_4808; t.u1 = 16'h8062; end
      default: begin t.u0 = 48'h804D_2000_804D; t.u1 = 16'h2000; end
    endcase
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  exp_t e_m, e_z, e_w;

  always @(negedge clk) begin
    if (rst_n && v_m && rm) begin
      if (q_m.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_m: unexpected word got %h expected none", u0_m);
      end else begin
        e_m = q_m.pop_front();
        chk("mon_m_u0", 64'(u0_m), 64'(e_m.u0));
        chk("mon_m_u1", 64'(u1_m), 64'(e_m.u1));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && v_z && rz) begin
      if (q_z.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_z: unexpected word got %h expected none", u0_z);
      end else begin
        e_z = q_z.pop_front();
        chk("mon_z_u0", 64'(u0_z), 64'(e_z.u0));
        chk("mon_z_u1", 64'(u1_z), 64'(e_z.u1));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && v_w && rw) begin
      if (q_w.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_w: unexpected word got %h expected none", u0_w);
      end else begin
        e_w = q_w.pop_front();
        chk("mon_w_u0", 64'(u0_w), 64'(e_w.u0));
        chk("mon_w_u1", 64'(u1_w), 64'(e_w.u1));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rs_m = 1'b0; rs_z = 1'b0; rs_w = 1'b0;
    rm = 1'b0; rz = 1'b1; rw = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 64'(v_m), 64'd0);
    chk("rst_u0", 64'(u0_m), 64'd0);
    chk("rst_u1", 64'(u1_m), 64'd0);
    chk("rst_busy", 64'(b_m), 64'd1);
    for (int i = 1; i <= 4; i++) q_z.push_back(mk(i));
    q_w.push_back(mk(4));
    rst_n = 1'b1;
    fork
      begin
        for (int k = 1; k <= 3; k++) begin
          @(posedge clk);
          #2;
          chk("lat_m_valid", 64'(v_m), 64'(k >= 2));
          chk("lat_m_busy", 64'(b_m), 64'd0);
        end
        for (int i = 0; i < 5; i++) begin
          chk("hold_valid", 64'(v_m), 64'd1);
          chk("hold_u0", 64'(u0_m), 64'(mk(1).u0));
          @(posedge clk);
          #2;
        end
        for (int i = 1; i <= 3; i++) q_m.push_back(mk(i));
        rm = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rm = 1'b0;
        chk("held_w4", 64'(u0_m), 64'(mk(4).u0));
        q_m.push_back(mk(4));
        rm = 1'b1;
        rs_m = 1'b1;
        @(posedge clk);
        #2;
        rs_m = 1'b0;
        chk("reseed_valid", 64'(v_m), 64'd0);
        chk("reseed_busy", 64'(b_m), 64'd1);
        q_m.push_back(mk(1));
        q_m.push_back(mk(2));
        repeat (4) @(posedge clk);
        #2;
        rm = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(v_m), 64'd0);
        chk("async_u0", 64'(u0_m), 64'd0);
        chk("async_u1", 64'(u1_m), 64'd0);
        chk("async_busy", 64'(b_m), 64'd1);
        chk("async_z_valid", 64'(v_z), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("restart_valid", 64'(v_m), 64'd1);
        q_m.push_back(mk(1));
        rm = 1'b1;
        @(posedge clk);
        #2;
        rm = 1'b0;
        repeat (3) @(posedge clk);
      end
      begin
        for (int k = 1; k <= 6; k++) begin
          @(posedge clk);
          #2;
          chk("lat_w_valid", 64'(v_w), 64'(k >= 5));
          chk("lat_w_busy", 64'(b_w), 64'(k <= 3));
          if (k == 6) begin
            rw = 1'b0;
            rz = 1'b0;
          end
        end
      end
    join
    chk("q_m_empty", 64'(q_m.size()), 64'd0);
    chk("q_z_empty", 64'(q_z.size()), 64'd0);
    chk("q_w_empty", 64'(q_w.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
